// File: rtl/inperiph.sv
// inperiph -- memory-mapped receive peripheral.
//
// An external byte source pushes bytes into a DEPTH-entry FIFO over a
// valid/ready handshake. The CPU inspects the FIFO head and status through
// four word registers and pops or clears the FIFO with control writes.
// A level interrupt is raised while occupancy is at or above a programmable
// threshold.
//
// Register map (daddr[3:2]):
//   0 DATA   R: {23'b0, valid, head_byte}            W: ignored
//   1 STATUS R: {16'b0, count[7:0], 5'b0, irq, full, empty}  W: ignored
//   2 CTRL   W: bit0 POP, bit1 CLEAR                 R: 0
//   3 THRESH R/W: [AW:0] threshold, 0 disables irq
//
// Ports:
//   clk       system clock, all state on posedge
//   reset     synchronous, active-high
//   daddr     CPU byte address (only [3:2] decoded)
//   drdata    combinational register read data
//   dwdata    CPU write data
//   dwe       byte write enables; a register write needs dwe[0]
//   in_valid  source presents in_data
//   in_data   byte from source
//   in_ready  FIFO can accept (count != DEPTH)
//   irq       registered level interrupt

module inperiph #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  output logic [31:0] drdata,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        irq
);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_sel_e;

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   thresh;

  reg_sel_e      sel;
  logic          empty;
  logic          full;
  logic          reg_wr;
  logic          ctrl_wr;
  logic          thresh_wr;
  logic          push_ok;
  logic          pop_ok;
  logic          clear;
  logic [7:0]    head_byte;

  assign sel       = reg_sel_e'(daddr[3:2]);
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign in_ready  = !full;

  assign reg_wr    = dwe[0];
  assign ctrl_wr   = reg_wr && (sel == REG_CTRL);
  assign thresh_wr = reg_wr && (sel == REG_THRESH);

  assign push_ok   = in_valid && in_ready;
  assign pop_ok    = ctrl_wr && dwdata[0] && !empty;
  assign clear     = ctrl_wr && dwdata[1];

  assign head_byte = empty ? 8'h00 : mem[rd_ptr];

  // Storage is deliberately left out of reset; the pointers and count define
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // CLEAR wins over a same-cycle push and pop: the handshaked byte is dropped
  // even though the source saw in_ready high.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thresh <= '0;
    end else if (thresh_wr) begin
      thresh <= dwdata[AW:0];
    end
  end

  // irq is computed from the current registers, so it trails any change of
  // count or thresh by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (thresh != '0) && (count >= thresh);
    end
  end

  always_comb begin
    drdata = '0;
    unique case (sel)
      REG_DATA:   drdata = {23'b0, !empty, head_byte};
      REG_STATUS: drdata = {16'b0, 8'(count), 5'b0, irq, full, empty};
      REG_CTRL:   drdata = '0;
      REG_THRESH: drdata = 32'(thresh);
      default:    drdata = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{daddr[31:4], daddr[1:0], dwdata[31:AW+1], dwe[3:1]};

endmodule
